// File: rtl/conv_line_buffer.sv
// Line buffer feeding the convolution row array: turns a raster pixel stream into
// vertically aligned KERNEL_SIZE-pixel columns, one per accepted pixel once the window is full.
module conv_line_buffer #(
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_BW     = 8,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int COL_BW      = 6,
  parameter int ROW_BW      = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic signed [DATA_BW-1:0]        i_x,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [KERNEL_SIZE*DATA_BW-1:0]   o_x_col,
  output logic [ROW_BW-1:0]                o_row,
  output logic [COL_BW-1:0]                o_col,
  output logic                             o_busy,
  output logic                             o_frame_done
);

  localparam int NLB = KERNEL_SIZE - 1;
  localparam int AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t                          state, state_nxt;
  logic [COL_BW-1:0]               col;
  logic [ROW_BW-1:0]               row;
  logic signed [DATA_BW-1:0]       lb [NLB][IMG_W];
  logic [AW-1:0]                   addr;
  logic                            accept, drain, col_end, last_fill, last_frame, emit;
  logic [KERNEL_SIZE*DATA_BW-1:0]  col_nxt;

  assign o_ready    = ((state == FILL) || (state == STREAM)) && (!o_valid || i_ready);
  assign accept     = i_valid && o_ready;
  assign drain      = o_valid && i_ready;
  assign o_busy     = (state != IDLE);
  assign addr       = col[AW-1:0];
  assign col_end    = (col == COL_BW'(IMG_W - 1));
  assign last_fill  = accept && col_end && (row == ROW_BW'(KERNEL_SIZE - 2));
  assign last_frame = accept && col_end && (row == ROW_BW'(IMG_H - 1));
  assign emit       = accept && (row >= ROW_BW'(KERNEL_SIZE - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start)    state_nxt = FILL;
      FILL:    if (last_fill)  state_nxt = STREAM;
      STREAM:  if (last_frame) state_nxt = DRAIN;
      DRAIN:   if (drain)      state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Newest pixel on the top slice, oldest buffered row on slice 0.
  always_comb begin
    col_nxt = '0;
    col_nxt[(KERNEL_SIZE-1)*DATA_BW +: DATA_BW] = i_x;
    for (int j = 0; j < NLB; j++)
      col_nxt[(KERNEL_SIZE-2-j)*DATA_BW +: DATA_BW] = lb[j][addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_x_col      <= '0;
      o_row        <= '0;
      o_col        <= '0;
    end else begin
      state        <= state_nxt;
      o_frame_done <= (state == DRAIN) && drain;
      if ((state == IDLE) && i_start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row + ROW_BW'(1);
        end else begin
          col <= col + COL_BW'(1);
        end
      end
      // Reload on accept takes priority so drain+accept streams one column per cycle.
      if (emit) begin
        o_valid <= 1'b1;
        o_x_col <= col_nxt;
        o_row   <= row - ROW_BW'(KERNEL_SIZE - 1);
        o_col   <= col;
      end else if (drain) begin
        o_valid <= 1'b0;
      end
    end
  end

  // Row shift: the read above sees the old contents, so each column moves down one row.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][addr] <= i_x;
      for (int j = 1; j < NLB; j++)
        lb[j][addr] <= lb[j-1][addr];
    end
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer with a 3-row window on a 4x4 frame;
// pixel value = offset + row*16 + col.
module tb_conv_line_buffer;

  logic        clk = 1'b0;
  logic        rst, i_start, i_valid, i_ready;
  logic [7:0]  i_x;
  logic        o_ready, o_valid, o_busy, o_frame_done;
  logic [23:0] o_x_col;
  logic [2:0]  o_row, o_col;

  typedef struct {
    logic [23:0] xc;
    logic [2:0]  row;
    logic [2:0]  col;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   out_cnt = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;

  conv_line_buffer #(
    .KERNEL_SIZE(3), .DATA_BW(8), .IMG_W(4), .IMG_H(4), .COL_BW(3), .ROW_BW(3)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .o_valid(o_valid), .i_ready(i_ready), .o_x_col(o_x_col),
    .o_row(o_row), .o_col(o_col), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: compare each drained column against the oldest expected entry.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    cyc++;
    if (o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got col=%h row=%0d c=%0d, no output expected",
                 o_x_col, o_row, o_col);
      end else begin
        e = exp_q.pop_front();
        if (o_x_col !== e.xc || o_row !== e.row || o_col !== e.col) begin
          errors++;
          $display("FAIL scoreboard: got col=%h row=%0d c=%0d, expected col=%h row=%0d c=%0d",
                   o_x_col, o_row, o_col, e.xc, e.row, e.col);
        end
      end
      out_cnt++;
      if (out_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int r, input int c, input logic [7:0] off);
    pv = off + 8'(r * 16 + c);
  endfunction

  // Send one pixel; returns at the negedge following the accepting clock edge.
  task automatic px(input int r, input int c, input logic [7:0] off);
    exp_t e;
    bit   acc;
    if (r >= 2) begin
      e.xc  = {pv(r, c, off), pv(r - 1, c, off), pv(r - 2, c, off)};
      e.row = 3'(r - 2);
      e.col = 3'(c);
      exp_q.push_back(e);
    end
    i_valid = 1'b1;
    i_x     = pv(r, c, off);
    acc     = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = o_ready;
      @(negedge clk);
    end
    i_valid = 1'b0;
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: pixel %h not accepted, expected accept", pv(r, c, off));
    end
  endtask

  task automatic pixels(input logic [7:0] off, input int first, input int n);
    for (int i = first; i < first + n; i++) px(i / 4, i % 4, off);
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      #1;
      seen = o_frame_done;
      @(negedge clk);
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_ready"}, 32'(o_ready), 0);
    chk({tag, "_busy"},  32'(o_busy), 0);
    chk({tag, "_done"},  32'(o_frame_done), 0);
    chk({tag, "_xcol"},  32'(o_x_col), 0);
    chk({tag, "_row"},   32'(o_row), 0);
    chk({tag, "_col"},   32'(o_col), 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_x = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);

    // Fill, first output, backpressure and row wrap.
    start_frame();
    chk("busy_after_start", 32'(o_busy), 1);
    pixels(8'h00, 0, 8);
    chk("fill_no_valid", 32'(o_valid), 0);
    px(2, 0, 8'h00);
    chk("first_valid", 32'(o_valid), 1);
    chk("first_xcol", 32'(o_x_col), 32'h201000);
    chk("first_row", 32'(o_row), 0);
    chk("first_col", 32'(o_col), 0);
    px(2, 1, 8'h00);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_x     = 8'h22;
    repeat (3) begin
      #1;
      chk("bp_ready", 32'(o_ready), 0);
      chk("bp_xcol", 32'(o_x_col), 32'h211101);
      chk("bp_col", 32'(o_col), 1);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    px(2, 2, 8'h00);
    px(2, 3, 8'h00);
    chk("wrap_col_a", 32'(o_col), 3);
    chk("wrap_row_a", 32'(o_row), 0);
    chk("wrap_s0_a", 32'(o_x_col[7:0]), 32'h03);
    px(3, 0, 8'h00);
    chk("wrap_col_b", 32'(o_col), 0);
    chk("wrap_row_b", 32'(o_row), 1);
    chk("wrap_s0_b", 32'(o_x_col[7:0]), 32'h10);
    pixels(8'h00, 13, 3);
    wait_done();

    // Full frame back to back.
    out_cnt = 0;
    start_frame();
    pixels(8'h00, 0, 16);
    chk("last_xcol", 32'(o_x_col), 32'h332313);
    chk("last_row", 32'(o_row), 1);
    chk("last_col", 32'(o_col), 3);
    @(negedge clk);
    chk("done_pulse", 32'(o_frame_done), 1);
    chk("done_valid", 32'(o_valid), 0);
    chk("done_busy", 32'(o_busy), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(o_frame_done), 0);
    chk("frame_out_cnt", 32'(out_cnt), 8);
    chk("contiguous", 32'(last_cyc - first_cyc), 7);

    // Reset mid-frame, then a fresh frame with offset values.
    start_frame();
    pixels(8'h00, 0, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    start_frame();
    pixels(8'h80, 0, 8);
    chk("refill_no_valid", 32'(o_valid), 0);
    px(2, 0, 8'h80);
    chk("refill_xcol", 32'(o_x_col), 32'hA09080);
    pixels(8'h80, 9, 7);
    wait_done();

    // Protocol: valid in IDLE ignored, start mid-stream ignored.
    i_valid = 1'b1;
    i_x     = 8'h55;
    repeat (2) begin
      #1;
      chk("idle_ready", 32'(o_ready), 0);
      chk("idle_busy", 32'(o_busy), 0);
      @(negedge clk);
    end
    i_valid = 1'b0;
    out_cnt = 0;
    start_frame();
    pixels(8'h00, 0, 10);
    i_start = 1'b1;
    px(2, 2, 8'h00);
    i_start = 1'b0;
    pixels(8'h00, 11, 5);
    wait_done();
    chk("proto_out_cnt", 32'(out_cnt), 8);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
